// File: rtl/fft_pkg.sv
// Shared constants for the in-place radix-2 FFT: transform size, address/stage widths
// and the sequencer state encoding.
package fft_pkg;
  localparam int LOG2_NFFT = 5;
  localparam int NFFT      = 1 << LOG2_NFFT;
  localparam int ADDR_W    = LOG2_NFFT;
  localparam int TW_W      = LOG2_NFFT - 1;
  localparam int K_W       = LOG2_NFFT - 1;
  localparam int STAGE_W   = (LOG2_NFFT > 1) ? $clog2(LOG2_NFFT) : 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> operand pair and twiddle index.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [K_W-1:0]     i_k,
  output logic [ADDR_W-1:0]  o_addr1,
  output logic [ADDR_W-1:0]  o_addr2,
  output logic [TW_W-1:0]    o_tw_addr
);
  logic [ADDR_W-1:0] w_k;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_pos;
  logic [ADDR_W-1:0] w_grp;

  always_comb begin
    w_k       = {1'b0, i_k};
    w_span    = ADDR_W'(1) << i_stage;
    w_pos     = w_k & (w_span - ADDR_W'(1));
    w_grp     = w_k >> i_stage;
    // 32-bit shift amounts so stage+1 cannot wrap in a narrow stage field
    o_addr1   = (w_grp << (32'(i_stage) + 32'd1)) | w_pos;
    o_addr2   = o_addr1 | w_span;
    o_tw_addr = TW_W'(w_pos << (32'(ADDR_W - 1) - 32'(i_stage)));
  end
endmodule

// File: rtl/fft_ctrl.sv
// FFT stage/butterfly sequencer: issues one butterfly read per cycle, drains the
// datapath between stages and replays read addresses as write-back addresses.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               rd_en_o,
  output logic [ADDR_W-1:0]  rd_addr1_o,
  output logic [ADDR_W-1:0]  rd_addr2_o,
  output logic [TW_W-1:0]    tw_addr_o,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr1_o,
  output logic [ADDR_W-1:0]  wr_addr2_o
);
  // state  | meaning
  // IDLE   | waiting for start_i
  // RUN    | one butterfly read per cycle, k = 0..NFFT/2-1
  // DRAIN  | PIPE_LAT idle cycles so the stage's writes land before the next reads
  // DONE   | one-cycle done_o pulse
  localparam int DCNT_W = 2;
  localparam logic [K_W-1:0]     K_LAST     = K_W'(NFFT / 2 - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2_NFFT - 1);

  state_t              r_state;
  logic [STAGE_W-1:0]  r_stage;
  logic [K_W-1:0]      r_k;
  logic [DCNT_W-1:0]   r_dcnt;

  state_t              w_state_nx;
  logic [STAGE_W-1:0]  w_stage_nx;
  logic [K_W-1:0]      w_k_nx;
  logic [DCNT_W-1:0]   w_dcnt_nx;
  logic [ADDR_W-1:0]   w_addr1;
  logic [ADDR_W-1:0]   w_addr2;
  logic [TW_W-1:0]     w_tw;

  logic [PIPE_LAT-1:0] r_pipe_en;
  logic [ADDR_W-1:0]   r_pipe_a1 [PIPE_LAT];
  logic [ADDR_W-1:0]   r_pipe_a2 [PIPE_LAT];

  always_comb begin
    w_state_nx = r_state;
    w_stage_nx = r_stage;
    w_k_nx     = r_k;
    w_dcnt_nx  = r_dcnt;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nx = ST_RUN;
          w_stage_nx = '0;
          w_k_nx     = '0;
        end
      end
      ST_RUN: begin
        if (r_k == K_LAST) begin
          w_state_nx = ST_DRAIN;
          w_dcnt_nx  = DCNT_W'(PIPE_LAT - 1);
        end else begin
          w_k_nx = r_k + K_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_dcnt == '0) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nx = ST_DONE;
          end else begin
            w_state_nx = ST_RUN;
            w_stage_nx = r_stage + STAGE_W'(1);
            w_k_nx     = '0;
          end
        end else begin
          w_dcnt_nx = r_dcnt - DCNT_W'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Addresses are generated from next-state counters so they register alongside rd_en_o
  fft_addr_gen u_addr_gen (
    .i_stage   (w_stage_nx),
    .i_k       (w_k_nx),
    .o_addr1   (w_addr1),
    .o_addr2   (w_addr2),
    .o_tw_addr (w_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_k        <= '0;
      r_dcnt     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      stage_o    <= '0;
      rd_en_o    <= 1'b0;
      rd_addr1_o <= '0;
      rd_addr2_o <= '0;
      tw_addr_o  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_stage    <= w_stage_nx;
      r_k        <= w_k_nx;
      r_dcnt     <= w_dcnt_nx;
      busy_o     <= (w_state_nx == ST_RUN) || (w_state_nx == ST_DRAIN);
      done_o     <= (w_state_nx == ST_DONE);
      stage_o    <= w_stage_nx;
      rd_en_o    <= (w_state_nx == ST_RUN);
      rd_addr1_o <= w_addr1;
      rd_addr2_o <= w_addr2;
      tw_addr_o  <= w_tw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_en <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pipe_a1[i] <= '0;
        r_pipe_a2[i] <= '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        r_pipe_en[i] <= r_pipe_en[i-1];
        r_pipe_a1[i] <= r_pipe_a1[i-1];
        r_pipe_a2[i] <= r_pipe_a2[i-1];
      end
      r_pipe_en[0] <= rd_en_o;
      r_pipe_a1[0] <= rd_addr1_o;
      r_pipe_a2[0] <= rd_addr2_o;
    end
  end

  assign wr_en_o    = r_pipe_en[PIPE_LAT-1];
  assign wr_addr1_o = r_pipe_a1[PIPE_LAT-1];
  assign wr_addr2_o = r_pipe_a2[PIPE_LAT-1];
endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Sequencer for the in-place radix-2 DIT FFT built around the combinational butterfly.
- Steps through all LOG2_NFFT stages and NFFT/2 butterflies per stage. Drives read addresses, write-back addresses and twiddle-ROM addresses for a dual-port sample RAM.
- Inserts drain cycles between stages so no read overtakes an outstanding write.
- Sits between the input loader (which leaves data in bit-reversed order) and the output unloader.

Parameters:
- LOG2_NFFT, 5: log2 of transform size; NFFT = 2**LOG2_NFFT.
- PIPE_LAT, 1: cycles from a read-address cycle to the matching write-back cycle (RAM read latency plus any datapath registers); legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse when the transform is complete.
- stage_o  out  $clog2(LOG2_NFFT)  current stage index.
- rd_en_o  out  1  RAM read strobe.
- rd_addr1_o, rd_addr2_o  out  LOG2_NFFT  butterfly operand addresses (upper/lower leg).
- tw_addr_o  out  LOG2_NFFT-1  twiddle ROM index, aligned with rd_en_o.
- wr_en_o  out  1  RAM write strobe for both butterfly outputs.
- wr_addr1_o, wr_addr2_o  out  LOG2_NFFT  write-back addresses for out1 and out2.

Behaviour:
- All outputs are registered. On rst, every output goes to 0, the state goes to IDLE and the counters clear. The reset takes effect immediately, including mid-transform; the partial transform is abandoned and no further writes are issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: if start_i=1 at a clock edge, go to RUN with stage=0, k=0.
- RUN: exactly one butterfly per cycle; rd_en_o=1.
  - k counts 0..NFFT/2-1.
  - At k=NFFT/2-1, go to DRAIN and clear the drain counter.
- DRAIN: rd_en_o=0 for PIPE_LAT cycles. Then:
  - if stage<LOG2_NFFT-1: stage++, k=0, back to RUN;
  - else: go to DONE.
- DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
- start_i is ignored outside IDLE; a held-high start_i restarts only after returning to IDLE.
- Address generation for stage s and butterfly k:
  - span = 1<<s; pos = k & (span-1); grp = k>>s.
  - rd_addr1 = (grp<<(s+1)) | pos; rd_addr2 = rd_addr1 + span.
  - tw_addr = pos << (LOG2_NFFT-1-s), truncated to LOG2_NFFT-1 bits.
- Write path: a PIPE_LAT-deep shift register carries {rd_en, rd_addr1, rd_addr2}. Its output drives {wr_en, wr_addr1, wr_addr2}, so each write lands exactly PIPE_LAT cycles after its read.
  - The shift register is cleared by rst.
  - Writes from the final stage complete inside the final DRAIN.
- Timing: the start edge is cycle 0.
  - RUN for stage s occupies cycles s*(NFFT/2+PIPE_LAT)+1 .. +NFFT/2.
  - done_o is high in cycle LOG2_NFFT*(NFFT/2+PIPE_LAT)+1; this is cycle 86 for the defaults.
- wr_en_o and rd_en_o may be high in the same cycle within a stage; addresses never collide because each butterfly touches a disjoint pair.

Decomposition:
- Shared package fft_pkg holds:
  - LOG2_NFFT and NFFT constants;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - address and stage width constants. The butterfly and RAM wrappers share these.
- One sub-module: fft_addr_gen, a combinational stage/k → addr1/addr2/tw_addr generator. It is reused by the unloader's bit-reverse variant.
- The delay line stays inline.

Test Plan:
- Reset, then start_i pulse at cycle 0 → busy_o=1 at cycle 1; at cycle 1 rd_addr1=0, rd_addr2=1, tw=0; at cycle 2 addresses 2/3; wr_en_o first high at cycle 2 with wr_addr 0/1.
- Stage 2, k=5 → rd_addr1=9, rd_addr2=13, tw_addr=4. Stage 4, k=3 → 3/19, tw_addr=3. Every address 0..31 is read exactly once per stage.
- Full run, defaults → 80 rd_en_o cycles and 80 wr_en_o cycles; rd_en_o=0 at cycles 17, 34, 51, 68, 85; done_o pulses only at cycle 86; back in IDLE at cycle 87.
- start_i held high throughout → second transform begins with the start edge in the cycle after DONE; pulses mid-run are ignored (no counter disturbance).
- rst asserted at cycle 40 → all outputs 0 immediately; no wr_en_o afterwards; a new start_i then produces an exact replay from stage 0.
- PIPE_LAT=2 with butterfly and RAM model, impulse at x[0]=0x0100 → all 32 outputs equal 0x0100 real, 0 imaginary; done_o at cycle 5*18+1=91.
